// File: rtl/chess_move_ctrl.sv
// Turn-sequencing controller: validates square selections against the side to move,
// drives the move generator, checks the destination and commits the move via one write port.
module chess_move_ctrl #(
  parameter int unsigned GEN_LAT = 2,
  parameter int unsigned CNT_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_valid,
  input  logic [5:0]             sel_pos,
  input  logic [7:0][7:0][3:0]   board,
  output logic [3:0]             gen_figure,
  output logic [5:0]             gen_position,
  input  logic [63:0]            gen_moves,
  output logic                   wr_en,
  output logic [5:0]             wr_pos,
  output logic [3:0]             wr_data,
  output logic                   turn,
  output logic [63:0]            highlight,
  output logic [5:0]             src_pos,
  output logic                   move_done,
  output logic                   illegal,
  output logic                   game_over,
  output logic [CNT_W-1:0]       move_count
);

  localparam int unsigned      LAT_W    = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(GEN_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_WAIT_DST, S_WR_DST, S_WR_SRC, S_DONE, S_HALT
  } state_t;

  state_t             r_state, w_state;
  logic [LAT_W-1:0]   r_cnt, w_cnt;
  logic               r_turn, w_turn;
  logic [63:0]        r_highlight, w_highlight;
  logic [5:0]         r_src, w_src;
  logic [3:0]         r_fig, w_fig;
  logic               r_wr_en, w_wr_en;
  logic [5:0]         r_wr_pos, w_wr_pos;
  logic [3:0]         r_wr_data, w_wr_data;
  logic               r_move_done, w_move_done;
  logic               r_illegal, w_illegal;
  logic               r_game_over, w_game_over;
  logic               r_king_hit, w_king_hit;
  logic [CNT_W-1:0]   r_count, w_count;

  logic [3:0]         w_sel_code;
  logic               w_sel_own;
  logic [3:0]         w_promo;

  function automatic logic f_own(input logic [3:0] code, input logic side);
    if (side) return (code >= 4'd7) && (code <= 4'd12);
    return (code >= 4'd1) && (code <= 4'd6);
  endfunction

  assign w_sel_code = board[sel_pos[5:3]][sel_pos[2:0]];
  assign w_sel_own  = f_own(w_sel_code, r_turn);

  always_comb begin
    w_promo = r_fig;
    if (r_fig == 4'd1 && sel_pos[5:3] == 3'd0) w_promo = 4'd5;
    if (r_fig == 4'd7 && sel_pos[5:3] == 3'd7) w_promo = 4'd11;
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_turn      = r_turn;
    w_highlight = r_highlight;
    w_src       = r_src;
    w_fig       = r_fig;
    w_wr_en     = 1'b0;
    w_wr_pos    = r_wr_pos;
    w_wr_data   = r_wr_data;
    w_move_done = 1'b0;
    w_illegal   = 1'b0;
    w_game_over = r_game_over;
    w_king_hit  = r_king_hit;
    w_count     = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (sel_valid) begin
          if (w_sel_own) begin
            w_src   = sel_pos;
            w_fig   = w_sel_code;
            w_cnt   = '0;
            w_state = S_GEN;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_GEN: begin
        if (r_cnt == LAT_LAST) begin
          if (gen_moves == '0) begin
            w_illegal   = 1'b1;
            w_highlight = '0;
            w_state     = S_IDLE;
          end else begin
            w_highlight = gen_moves;
            w_state     = S_WAIT_DST;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_WAIT_DST: begin
        if (sel_valid) begin
          if (sel_pos == r_src) begin
            w_highlight = '0;
            w_state     = S_IDLE;
          end else if (w_sel_own) begin
            w_src   = sel_pos;
            w_fig   = w_sel_code;
            w_cnt   = '0;
            w_state = S_GEN;
          end else if (r_highlight[sel_pos]) begin
            // Captured piece is sampled now; board is not read again until the move is done.
            w_king_hit = (w_sel_code == 4'd6) || (w_sel_code == 4'd12);
            w_wr_en    = 1'b1;
            w_wr_pos   = sel_pos;
            w_wr_data  = w_promo;
            w_state    = S_WR_DST;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_WR_DST: begin
        w_wr_en     = 1'b1;
        w_wr_pos    = r_src;
        w_wr_data   = '0;
        w_game_over = r_game_over | r_king_hit;
        w_state     = S_WR_SRC;
      end
      S_WR_SRC: begin
        w_move_done = 1'b1;
        w_turn      = ~r_turn;
        w_count     = r_count + 1'b1;
        w_highlight = '0;
        w_state     = S_DONE;
      end
      S_DONE:  w_state = r_game_over ? S_HALT : S_IDLE;
      S_HALT:  w_state = S_HALT;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_turn      <= 1'b0;
      r_highlight <= '0;
      r_src       <= '0;
      r_fig       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_pos    <= '0;
      r_wr_data   <= '0;
      r_move_done <= 1'b0;
      r_illegal   <= 1'b0;
      r_game_over <= 1'b0;
      r_king_hit  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_turn      <= w_turn;
      r_highlight <= w_highlight;
      r_src       <= w_src;
      r_fig       <= w_fig;
      r_wr_en     <= w_wr_en;
      r_wr_pos    <= w_wr_pos;
      r_wr_data   <= w_wr_data;
      r_move_done <= w_move_done;
      r_illegal   <= w_illegal;
      r_game_over <= w_game_over;
      r_king_hit  <= w_king_hit;
      r_count     <= w_count;
    end
  end

  assign gen_figure   = r_fig;
  assign gen_position = r_src;
  assign src_pos      = r_src;
  assign wr_en        = r_wr_en;
  assign wr_pos       = r_wr_pos;
  assign wr_data      = r_wr_data;
  assign turn         = r_turn;
  assign highlight    = r_highlight;
  assign move_done    = r_move_done;
  assign illegal      = r_illegal;
  assign game_over    = r_game_over;
  assign move_count   = r_count;

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Bench for chess_move_ctrl: directed test-plan scenarios plus random games, checked every
// cycle against a schedule of expected output snapshots built from the move rules.
module tb_chess_move_ctrl;
  localparam int unsigned GEN_LAT = 2;
  localparam int unsigned CNT_W   = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sel_valid = 1'b0;
  logic [5:0]           sel_pos = '0;
  logic [7:0][7:0][3:0] board = '0;
  logic [3:0]           gen_figure;
  logic [5:0]           gen_position;
  logic [63:0]          gen_moves = '0;
  logic                 wr_en;
  logic [5:0]           wr_pos;
  logic [3:0]           wr_data;
  logic                 turn;
  logic [63:0]          highlight;
  logic [5:0]           src_pos;
  logic                 move_done;
  logic                 illegal;
  logic                 game_over;
  logic [CNT_W-1:0]     move_count;

  chess_move_ctrl #(.GEN_LAT(GEN_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_pos(sel_pos), .board(board),
    .gen_figure(gen_figure), .gen_position(gen_position), .gen_moves(gen_moves),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_data(wr_data), .turn(turn), .highlight(highlight),
    .src_pos(src_pos), .move_done(move_done), .illegal(illegal), .game_over(game_over),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             wr_en;
    logic [5:0]       wr_pos;
    logic [3:0]       wr_data;
    logic             illegal;
    logic             move_done;
    logic             turn;
    logic [63:0]      hl;
    logic [5:0]       src;
    logic [3:0]       fig;
    logic             game_over;
    logic [CNT_W-1:0] cnt;
  } snap_t;

  snap_t       cur;
  snap_t       ce;
  snap_t       sched[$];
  bit          m_sel, m_halt;
  int          n_cmp = 0, n_bad = 0;
  int          n_ill = 0, n_done = 0, n_wr = 0;
  logic [63:0] gen_tab [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the next scheduled snapshot (steady snapshot when none pending).
  always @(negedge clk) begin
    if (sched.size() > 0) ce = sched.pop_front();
    else ce = cur;
    chk("wr_en", 64'(wr_en), 64'(ce.wr_en));
    if (ce.wr_en) begin
      chk("wr_pos", 64'(wr_pos), 64'(ce.wr_pos));
      chk("wr_data", 64'(wr_data), 64'(ce.wr_data));
    end
    chk("illegal", 64'(illegal), 64'(ce.illegal));
    chk("move_done", 64'(move_done), 64'(ce.move_done));
    chk("turn", 64'(turn), 64'(ce.turn));
    chk("highlight", highlight, ce.hl);
    chk("src_pos", 64'(src_pos), 64'(ce.src));
    chk("gen_position", 64'(gen_position), 64'(ce.src));
    chk("gen_figure", 64'(gen_figure), 64'(ce.fig));
    chk("game_over", 64'(game_over), 64'(ce.game_over));
    chk("move_count", 64'(move_count), 64'(ce.cnt));
    if (illegal) n_ill++;
    if (move_done) n_done++;
    if (wr_en) n_wr++;
  end

  // Move generator: garbage until its inputs have been stable GEN_LAT cycles.
  int         gen_age = 0;
  logic [3:0] last_fig = '0;
  logic [5:0] last_pos = '0;
  always @(posedge clk) begin
    #1;
    if (gen_figure !== last_fig || gen_position !== last_pos) gen_age = 0;
    else gen_age++;
    last_fig = gen_figure;
    last_pos = gen_position;
    gen_moves = (gen_age >= int'(GEN_LAT) - 1) ? gen_tab[gen_position] : {$urandom, $urandom};
  end

  function automatic logic [3:0] sq(input logic [5:0] p);
    return board[p[5:3]][p[2:0]];
  endfunction

  function automatic bit own(input logic [3:0] c, input logic t);
    return t ? (c >= 4'd7 && c <= 4'd12) : (c >= 4'd1 && c <= 4'd6);
  endfunction

  task automatic step();
    logic we;
    logic [5:0] wp;
    logic [3:0] wd;
    @(negedge clk);
    we = wr_en; wp = wr_pos; wd = wr_data;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
    if (we === 1'b1) board[wp[5:3]][wp[2:0]] = wd;
  endtask

  task automatic model_reset();
    sched.delete();
    cur = '{default: '0};
    m_sel = 0;
    m_halt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sched.size() > 0; i++) step();
    chk("drain_timeout", 64'(sched.size()), 64'd0);
  endtask

  // Predicts the full reaction to one selection, then drives it.
  task automatic select(input logic [5:0] p, input bit noise, input bit abort);
    snap_t s;
    logic [3:0] c, wd;
    logic [63:0] m;
    bit busy;
    c = sq(p);
    busy = 0;
    sched.push_back(cur);
    if (m_halt) begin
      busy = 1;
    end else if (m_sel && p == cur.src) begin
      cur.hl = '0;
      m_sel = 0;
      sched.push_back(cur);
    end else if (own(c, cur.turn)) begin
      cur.src = p;
      cur.fig = c;
      for (int i = 0; i < int'(GEN_LAT); i++) sched.push_back(cur);
      m = gen_tab[p];
      if (m == '0) begin
        cur.hl = '0;
        s = cur; s.illegal = 1'b1;
        sched.push_back(s);
        m_sel = 0;
      end else begin
        cur.hl = m;
        sched.push_back(cur);
        m_sel = 1;
      end
      busy = (GEN_LAT >= 2);
    end else if (m_sel && cur.hl[p]) begin
      wd = cur.fig;
      if (cur.fig == 4'd1 && p / 8 == 0) wd = 4'd5;
      if (cur.fig == 4'd7 && p / 8 == 7) wd = 4'd11;
      s = cur; s.wr_en = 1'b1; s.wr_pos = p; s.wr_data = wd;
      sched.push_back(s);
      if (c == 4'd6 || c == 4'd12) cur.game_over = 1'b1;
      s = cur; s.wr_en = 1'b1; s.wr_pos = cur.src; s.wr_data = 4'd0;
      sched.push_back(s);
      cur.turn = ~cur.turn;
      cur.cnt = cur.cnt + 1'b1;
      cur.hl = '0;
      s = cur; s.move_done = 1'b1;
      sched.push_back(s);
      m_sel = 0;
      if (cur.game_over) m_halt = 1;
      busy = 1;
    end else begin
      s = cur; s.illegal = 1'b1;
      sched.push_back(s);
    end
    sel_valid = 1'b1;
    sel_pos = p;
    step();
    if (abort) begin
      rst = 1'b1;
      model_reset();
      step(); step();
      rst = 1'b0;
      step();
      return;
    end
    if (noise && busy) begin
      sel_valid = 1'b1;
      sel_pos = 6'($urandom_range(0, 63));
      step();
    end
    drain();
  endtask

  task automatic clear_setup();
    board = '0;
    for (int i = 0; i < 64; i++) gen_tab[i] = '0;
  endtask

  task automatic set_sq(input logic [5:0] p, input logic [3:0] c);
    board[p[5:3]][p[2:0]] = c;
  endtask

  function automatic logic [5:0] pick_hl(input logic [63:0] hl);
    int st;
    st = $urandom_range(0, 63);
    for (int i = 0; i < 64; i++)
      if (hl[(st + i) % 64]) return 6'((st + i) % 64);
    return 6'(st);
  endfunction

  initial begin
    int ill0, wr0, done0, r;
    logic [5:0] p;
    logic [5:0] cand[$];
    model_reset();
    clear_setup();
    do_reset();

    // Opening pawn push e2-e4.
    set_sq(6'd52, 4'd1);
    gen_tab[52] = (64'd1 << 36) | (64'd1 << 44);
    select(6'd52, 1'b1, 1'b0);
    chk("lit_highlight", highlight, 64'h0000_1010_0000_0000);
    wr0 = n_wr;
    select(6'd36, 1'b0, 1'b0);
    chk("lit_writes", 64'(n_wr - wr0), 64'd2);
    chk("lit_dst", 64'(sq(6'd36)), 64'd1);
    chk("lit_src", 64'(sq(6'd52)), 64'd0);
    chk("lit_turn", 64'(turn), 64'd1);
    chk("lit_count", 64'(move_count), 64'd1);

    // White to move selecting a black piece.
    do_reset();
    chk("lit_reset_turn", 64'(turn), 64'd0);
    set_sq(6'd12, 4'd7);
    ill0 = n_ill; wr0 = n_wr;
    select(6'd12, 1'b0, 1'b0);
    chk("lit_ill_own", 64'(n_ill - ill0), 64'd1);
    chk("lit_ill_nowr", 64'(n_wr - wr0), 64'd0);

    // Illegal destination, then deselect.
    clear_setup();
    do_reset();
    set_sq(6'd52, 4'd1);
    gen_tab[52] = (64'd1 << 36) | (64'd1 << 44);
    select(6'd52, 1'b0, 1'b0);
    ill0 = n_ill; wr0 = n_wr;
    select(6'd20, 1'b0, 1'b0);
    chk("lit_ill_dst", 64'(n_ill - ill0), 64'd1);
    chk("lit_hl_kept", highlight, 64'h0000_1010_0000_0000);
    select(6'd52, 1'b0, 1'b0);
    chk("lit_desel_hl", highlight, 64'd0);
    chk("lit_desel_nowr", 64'(n_wr - wr0), 64'd0);

    // White promotion on row 0.
    set_sq(6'd8, 4'd1);
    gen_tab[8] = 64'd1;
    select(6'd8, 1'b0, 1'b0);
    select(6'd0, 1'b0, 1'b0);
    chk("lit_promo", 64'(sq(6'd0)), 64'd5);

    // King capture halts the game.
    clear_setup();
    do_reset();
    set_sq(6'd10, 4'd1);
    set_sq(6'd2, 4'd12);
    set_sq(6'd30, 4'd3);
    gen_tab[10] = 64'd1 << 2;
    select(6'd10, 1'b0, 1'b0);
    select(6'd2, 1'b0, 1'b0);
    chk("lit_game_over", 64'(game_over), 64'd1);
    ill0 = n_ill; wr0 = n_wr; done0 = n_done;
    for (int i = 0; i < 4; i++) select(6'($urandom_range(0, 63)), 1'b0, 1'b0);
    select(6'd30, 1'b0, 1'b0);
    chk("lit_halt_quiet", 64'((n_ill - ill0) + (n_wr - wr0) + (n_done - done0)), 64'd0);

    // Reset while the destination write is pending.
    clear_setup();
    do_reset();
    set_sq(6'd52, 4'd1);
    gen_tab[52] = (64'd1 << 36) | (64'd1 << 44);
    select(6'd52, 1'b0, 1'b0);
    select(6'd36, 1'b0, 1'b1);
    chk("lit_abort_wr", 64'(wr_en), 64'd0);
    chk("lit_abort_turn", 64'(turn), 64'd0);
    chk("lit_abort_cnt", 64'(move_count), 64'd0);
    chk("lit_abort_hl", highlight, 64'd0);
    chk("lit_abort_board", 64'(sq(6'd36)), 64'd0);

    // Random games.
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < 64; i++) begin
        board[i / 8][i % 8] = ($urandom_range(0, 99) < 50) ? 4'd0 : 4'($urandom_range(1, 15));
        gen_tab[i] = ($urandom_range(0, 99) < 15) ? 64'd0 : {$urandom, $urandom};
      end
      do_reset();
      for (int a = 0; a < 40; a++) begin
        if (m_halt) begin
          for (int k = 0; k < 3; k++) select(6'($urandom_range(0, 63)), 1'b1, 1'b0);
          break;
        end
        r = $urandom_range(0, 9);
        cand.delete();
        for (int i = 0; i < 64; i++) if (own(sq(6'(i)), cur.turn)) cand.push_back(6'(i));
        if (m_sel && r < 2) p = cur.src;
        else if (m_sel && r < 6) p = pick_hl(cur.hl);
        else if (r < 8 && cand.size() > 0) p = cand[$urandom_range(0, cand.size() - 1)];
        else p = 6'($urandom_range(0, 63));
        select(p, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
